// File: rtl/config_frame_pkg.sv
// rtl/config_frame_pkg.sv - shared constants, FSM states and word classifiers for the frame writer
//
// Contents:
//   SYNC_WORD / DESYNC_UPPER   bitstream framing constants
//   DEFAULT_STROBE_CYCLES      default strobe length in cycles
//   state_t                    writer FSM states
//   is_sync / is_desync        word classifiers
package config_frame_pkg;

  localparam logic [31:0] SYNC_WORD             = 32'hFAB0_FAB1;
  localparam logic [15:0] DESYNC_UPPER          = 16'hFAB0;
  localparam int          DEFAULT_STROBE_CYCLES = 2;

  typedef enum logic [2:0] {
    HUNT,
    ADDR,
    DATA,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  function automatic logic is_sync(input logic [31:0] word);
    return word == SYNC_WORD;
  endfunction

  // Same upper half as the sync word, any other lower half.
  function automatic logic is_desync(input logic [31:0] word);
    return (word[31:16] == DESYNC_UPPER) && (word[15:0] != SYNC_WORD[15:0]);
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// rtl/frame_strobe_decoder.sv - one-hot strobe decode of a 16-bit frame index
//
// Ports:
//   index   in  16        frame index, compared unsigned on all 16 bits
//   enable  in  1         strobe window is open
//   strobe  out NumLines  one-hot latch enable, all zero when disabled or index >= NumLines
module frame_strobe_decoder #(
  parameter int NumLines = 20
) (
  input  logic [15:0]         index,
  input  logic                enable,
  output logic [NumLines-1:0] strobe
);

  // Full-width compare per line: out-of-range indices match no line, so
  // high index bits can never alias onto a valid strobe.
  always_comb begin
    strobe = '0;
    for (int i = 0; i < NumLines; i++) begin
      strobe[i] = enable && (index == 16'(i));
    end
  end

endmodule

// File: rtl/config_frame_writer.sv
// rtl/config_frame_writer.sv - bitstream-to-frame-latch writer with set-up/hold-framed strobes
//
// Ports:
//   CLK, reset       clock, synchronous active-high reset
//   in_data/valid    32-bit bitstream word input, accepted when in_valid && in_ready
//   in_ready         high in HUNT, ADDR and DATA
//   FrameData        frame contents, changes only on an in-range DATA acceptance
//   FrameStrobe      one-hot latch enable, high StrobeCycles cycles per frame
//   busy             high outside HUNT
//   done             one-cycle pulse after desync acceptance
//   err              sticky out-of-range index flag
//   frames_written   wrapping count of completed frames
module config_frame_writer
  import config_frame_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int StrobeCycles    = DEFAULT_STROBE_CYCLES,
  parameter int CntWidth        = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [31:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [CntWidth-1:0]        frames_written
);

  // Counter holds remaining strobe cycles minus one.
  localparam int CW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

  state_t          state;
  logic [15:0]     index;
  logic [CW-1:0]   strobe_cnt;
  logic            accept;
  logic            index_in_range;

  assign in_ready       = (state == HUNT) || (state == ADDR) || (state == DATA);
  assign busy           = (state != HUNT);
  assign accept         = in_valid && in_ready;
  assign index_in_range = ({16'd0, index} < 32'(MaxFramesPerCol));

  always_ff @(posedge CLK) begin
    if (reset) begin
      state          <= HUNT;
      index          <= '0;
      FrameData      <= '0;
      strobe_cnt     <= '0;
      frames_written <= '0;
      err            <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        HUNT: begin
          if (accept && is_sync(in_data)) state <= ADDR;
        end
        ADDR: begin
          if (accept) begin
            if (is_desync(in_data)) begin
              done  <= 1'b1;
              state <= HUNT;
            end else if (!is_sync(in_data)) begin
              index <= in_data[15:0];
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            if (index_in_range) begin
              FrameData <= in_data[FrameBitsPerRow-1:0];
              state     <= SETUP;
            end else begin
              // Bad index: keep the latches' data untouched and skip the strobe.
              err   <= 1'b1;
              state <= ADDR;
            end
          end
        end
        SETUP: begin
          strobe_cnt <= CW'(StrobeCycles - 1);
          state      <= STROBE;
        end
        STROBE: begin
          if (strobe_cnt == '0) state <= HOLD;
          else                  strobe_cnt <= strobe_cnt - CW'(1);
        end
        HOLD: begin
          frames_written <= frames_written + CntWidth'(1);
          state          <= ADDR;
        end
        default: state <= HUNT;
      endcase
    end
  end

  frame_strobe_decoder #(
    .NumLines(MaxFramesPerCol)
  ) u_decoder (
    .index (index),
    .enable(state == STROBE),
    .strobe(FrameStrobe)
  );

endmodule
